layers_frame_merger: RTL and testbench

- Parametrised successor to the fixed 3-layer readout switch. Merges N per-layer frame streams (AXIS, tlast-delimited) into one output stream.
- Arbitrates round-robin with frame granularity: a granted layer keeps the grant until its tlast. Optionally prepends a layer-ID header word.
- Aborts stalled frames with a timeout marker. Buffers merged data in an internal FIFO of configurable depth before the RFG readout.

---
 rtl/layers_merger_pkg.sv | 44 ++++
 rtl/layers_frame_merger_fifo.sv | 56 +++++
 rtl/layers_frame_merger.sv | 162 ++++++++++++++++
 tb/tb_layers_frame_merger.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/layers_merger_pkg.sv
// Shared types and helpers for the layer frame merger and its output buffer.
package layers_merger_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_HEADER,
      ST_DATA,
      ST_ABORT
   } merger_state_t;

   localparam int MAX_LAYERS = 16;
   localparam logic [7:0] DEFAULT_TIMEOUT_MARKER = 8'hFF;

   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) begin
            result = i + 1;
         end
      end
      return result;
   endfunction

   // First candidate strictly after the pointer, wrapping at layer_count.
   function automatic logic [3:0] rr_pick(input logic [MAX_LAYERS-1:0] candidates,
                                          input logic [3:0] pointer,
                                          input int layer_count);
      logic [3:0] pick;
      logic       found;
      int         idx;
      pick  = pointer;
      found = 1'b0;
      for (int k = 1; k <= MAX_LAYERS; k++) begin
         idx = (int'(pointer) + k) % layer_count;
         if (!found && (k <= layer_count) && candidates[idx[3:0]]) begin
            pick  = idx[3:0];
            found = 1'b1;
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/layers_frame_merger_fifo.sv
// Single-clock first-word-fall-through FIFO; the head entry is visible one cycle after its write.
module sync_fifo_fwft
   import layers_merger_pkg::*;
#(
   parameter int WIDTH = 9,
   parameter int DEPTH = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    push,
   input  logic [WIDTH-1:0]        push_data,
   input  logic                    pop,
   output logic [WIDTH-1:0]        pop_data,
   output logic                    full,
   output logic                    empty,
   output logic [clog2(DEPTH):0]   count
);

   localparam int AW = clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_push;
   logic             do_pop;

   // A full FIFO refuses writes even if a pop frees a slot in the same cycle.
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   assign empty    = (wr_ptr == rd_ptr);
   assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign count    = wr_ptr - rd_ptr;
   assign pop_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr[AW-1:0]] <= push_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
      end
   end

endmodule

// File: rtl/layers_frame_merger.sv
// Merges per-layer AXIS frame streams round-robin at frame granularity into one buffered stream,
// with optional layer-ID header words and abort of stalled frames.
module layers_frame_merger
   import layers_merger_pkg::*;
#(
   parameter int LAYER_COUNT = 3,
   parameter int DATA_WIDTH  = 8,
   parameter int FIFO_DEPTH  = 1024,
   parameter logic [DATA_WIDTH-1:0] TIMEOUT_MARKER = DATA_WIDTH'(DEFAULT_TIMEOUT_MARKER)
) (
   input  logic                              clk_core,
   input  logic                              clk_core_resn,
   input  logic [LAYER_COUNT*DATA_WIDTH-1:0] s_axis_tdata,
   input  logic [LAYER_COUNT-1:0]            s_axis_tvalid,
   input  logic [LAYER_COUNT-1:0]            s_axis_tlast,
   output logic [LAYER_COUNT-1:0]            s_axis_tready,
   output logic [DATA_WIDTH-1:0]             m_axis_tdata,
   output logic                              m_axis_tvalid,
   output logic                              m_axis_tlast,
   input  logic                              m_axis_tready,
   output logic [31:0]                       data_count,
   input  logic [LAYER_COUNT-1:0]            cfg_enable_mask,
   input  logic                              cfg_insert_header,
   input  logic [15:0]                       cfg_timeout,
   output logic [LAYER_COUNT-1:0]            status_grant,
   output logic                              status_fifo_full,
   output logic [LAYER_COUNT-1:0]            stat_frame_done,
   output logic [LAYER_COUNT-1:0]            stat_timeout
);

   localparam int IW = (LAYER_COUNT > 1) ? clog2(LAYER_COUNT) : 1;
   localparam int CW = clog2(FIFO_DEPTH) + 1;

   merger_state_t         state;
   merger_state_t         state_next;
   logic [IW-1:0]         grant_idx;
   logic [IW-1:0]         grant_next;
   logic [IW-1:0]         pointer;
   logic [IW-1:0]         pointer_next;
   logic [15:0]           timer;
   logic [15:0]           timer_next;
   logic [LAYER_COUNT-1:0] candidates;
   logic [LAYER_COUNT-1:0] grant_onehot;
   logic [3:0]            pick;
   logic                  sel_valid;
   logic                  sel_last;
   logic [DATA_WIDTH-1:0] sel_data;
   logic                  timeout_hit;
   logic                  fifo_push;
   logic [DATA_WIDTH:0]   push_data;
   logic [DATA_WIDTH:0]   pop_data;
   logic                  fifo_full;
   logic                  fifo_empty;
   logic [CW-1:0]         fifo_count;

   assign candidates   = s_axis_tvalid & cfg_enable_mask;
   assign pick         = rr_pick(MAX_LAYERS'(candidates), 4'(pointer), LAYER_COUNT);
   assign grant_onehot = LAYER_COUNT'(1) << grant_idx;
   assign sel_valid    = s_axis_tvalid[grant_idx];
   assign sel_last     = s_axis_tlast[grant_idx];
   assign sel_data     = s_axis_tdata[grant_idx*DATA_WIDTH +: DATA_WIDTH];
   assign timeout_hit  = (cfg_timeout != 16'd0) && (timer == cfg_timeout);

   always_ff @(posedge clk_core or negedge clk_core_resn) begin
      if (!clk_core_resn) begin
         state     <= ST_IDLE;
         grant_idx <= '0;
         pointer   <= IW'(LAYER_COUNT - 1);
         timer     <= '0;
      end else begin
         state     <= state_next;
         grant_idx <= grant_next;
         pointer   <= pointer_next;
         timer     <= timer_next;
      end
   end

   // The owner keeps the grant until its tlast or an abort; the pointer only moves on a new grant.
   always_comb begin
      state_next      = state;
      grant_next      = grant_idx;
      pointer_next    = pointer;
      timer_next      = timer;
      fifo_push       = 1'b0;
      push_data       = '0;
      s_axis_tready   = '0;
      status_grant    = '0;
      stat_frame_done = '0;
      stat_timeout    = '0;
      case (state)
         ST_IDLE: begin
            timer_next = '0;
            if (|candidates) begin
               grant_next   = IW'(pick);
               pointer_next = IW'(pick);
               state_next   = cfg_insert_header ? ST_HEADER : ST_DATA;
            end
         end
         ST_HEADER: begin
            status_grant = grant_onehot;
            if (!fifo_full) begin
               fifo_push  = 1'b1;
               push_data  = {1'b0, DATA_WIDTH'(grant_idx) + DATA_WIDTH'(1)};
               state_next = ST_DATA;
            end
         end
         ST_DATA: begin
            status_grant = grant_onehot;
            if (timeout_hit) begin
               state_next = ST_ABORT;
            end else begin
               s_axis_tready = grant_onehot & {LAYER_COUNT{!fifo_full}};
               if (sel_valid && !fifo_full) begin
                  fifo_push  = 1'b1;
                  push_data  = {sel_last, sel_data};
                  timer_next = '0;
                  if (sel_last) begin
                     stat_frame_done = grant_onehot;
                     state_next      = ST_IDLE;
                  end
               end else if (!sel_valid && (cfg_timeout != 16'd0)) begin
                  timer_next = timer + 16'd1;
               end
            end
         end
         ST_ABORT: begin
            status_grant = grant_onehot;
            if (!fifo_full) begin
               fifo_push    = 1'b1;
               push_data    = {1'b1, TIMEOUT_MARKER};
               stat_timeout = grant_onehot;
               state_next   = ST_IDLE;
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   sync_fifo_fwft #(
      .WIDTH(DATA_WIDTH + 1),
      .DEPTH(FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk_core),
      .rst_n     (clk_core_resn),
      .push      (fifo_push),
      .push_data (push_data),
      .pop       (m_axis_tready),
      .pop_data  (pop_data),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   assign m_axis_tvalid    = !fifo_empty;
   assign m_axis_tlast     = pop_data[DATA_WIDTH];
   assign m_axis_tdata     = pop_data[DATA_WIDTH-1:0];
   assign data_count       = 32'(fifo_count);
   assign status_fifo_full = fifo_full;

endmodule

// File: tb/tb_layers_frame_merger.sv
// Directed bench for layers_frame_merger: per-layer frame sources, an output word monitor,
// a table of arbitration vectors and hand-written multi-cycle sequences.
module tb_layers_frame_merger;

   localparam int LC    = 3;
   localparam int DW    = 8;
   localparam int DEPTH = 16;

   typedef struct packed {
      logic          last;
      logic [DW-1:0] data;
   } word_t;

   typedef struct {
      logic [LC-1:0] en;
      logic [LC-1:0] mask;
      logic [DW-1:0] exp_first;
      logic [DW-1:0] exp_second;
   } arb_vec_t;

   logic                 clk_core = 1'b0;
   logic                 clk_core_resn = 1'b0;
   logic [LC*DW-1:0]     s_axis_tdata;
   logic [LC-1:0]        s_axis_tvalid;
   logic [LC-1:0]        s_axis_tlast;
   logic [LC-1:0]        s_axis_tready;
   logic [DW-1:0]        m_axis_tdata;
   logic                 m_axis_tvalid;
   logic                 m_axis_tlast;
   logic                 m_axis_tready = 1'b1;
   logic [31:0]          data_count;
   logic [LC-1:0]        cfg_enable_mask = '1;
   logic                 cfg_insert_header = 1'b1;
   logic [15:0]          cfg_timeout = '0;
   logic [LC-1:0]        status_grant;
   logic                 status_fifo_full;
   logic [LC-1:0]        stat_frame_done;
   logic [LC-1:0]        stat_timeout;

   logic [LC-1:0] src_en = '0;
   int            src_len [LC] = '{1, 1, 1};
   int            src_cnt [LC];
   int            src_seq [LC];

   word_t out_q[$];
   int    cyc = 0;
   int    timeout_pulses [LC];
   int    done_pulses [LC];
   int    last_timeout_cyc = -1;
   logic  watch_atomic = 1'b0;
   int    ready1_violations = 0;
   int    errors = 0;
   int    checks = 0;

   arb_vec_t vecs [6];

   layers_frame_merger #(
      .LAYER_COUNT (LC),
      .DATA_WIDTH  (DW),
      .FIFO_DEPTH  (DEPTH)
   ) dut (
      .clk_core          (clk_core),
      .clk_core_resn     (clk_core_resn),
      .s_axis_tdata      (s_axis_tdata),
      .s_axis_tvalid     (s_axis_tvalid),
      .s_axis_tlast      (s_axis_tlast),
      .s_axis_tready     (s_axis_tready),
      .m_axis_tdata      (m_axis_tdata),
      .m_axis_tvalid     (m_axis_tvalid),
      .m_axis_tlast      (m_axis_tlast),
      .m_axis_tready     (m_axis_tready),
      .data_count        (data_count),
      .cfg_enable_mask   (cfg_enable_mask),
      .cfg_insert_header (cfg_insert_header),
      .cfg_timeout       (cfg_timeout),
      .status_grant      (status_grant),
      .status_fifo_full  (status_fifo_full),
      .stat_frame_done   (stat_frame_done),
      .stat_timeout      (stat_timeout)
   );

   always #5 clk_core = ~clk_core;

   // Layer i sends bytes {i, seq[5:0]}; frames are src_len bytes long.
   always_comb begin
      s_axis_tdata  = '0;
      s_axis_tvalid = '0;
      s_axis_tlast  = '0;
      for (int i = 0; i < LC; i++) begin
         s_axis_tvalid[i]          = src_en[i];
         s_axis_tlast[i]           = (src_cnt[i] == src_len[i] - 1);
         s_axis_tdata[i*DW +: DW]  = 8'((i << 6) | (src_seq[i] & 63));
      end
   end

   always @(posedge clk_core or negedge clk_core_resn) begin
      if (!clk_core_resn) begin
         for (int i = 0; i < LC; i++) begin
            src_cnt[i] <= 0;
            src_seq[i] <= 0;
         end
      end else begin
         for (int i = 0; i < LC; i++) begin
            if (s_axis_tvalid[i] && s_axis_tready[i]) begin
               src_seq[i] <= src_seq[i] + 1;
               src_cnt[i] <= s_axis_tlast[i] ? 0 : src_cnt[i] + 1;
            end
         end
      end
   end

   // Inputs only change just after a rising edge, so handshakes seen here complete on the next edge.
   always @(negedge clk_core) begin
      cyc++;
      if (clk_core_resn) begin
         if (watch_atomic && s_axis_tready[1] && (done_pulses[0] == 0)) begin
            ready1_violations++;
         end
         if (m_axis_tvalid && m_axis_tready) begin
            out_q.push_back({m_axis_tlast, m_axis_tdata});
         end
         for (int i = 0; i < LC; i++) begin
            if (stat_timeout[i]) begin
               timeout_pulses[i]++;
            end
            if (stat_frame_done[i]) begin
               done_pulses[i]++;
            end
         end
         if (stat_timeout[2]) begin
            last_timeout_cyc = cyc;
         end
      end
   end

   function automatic word_t word_at(input int k);
      if (k < out_q.size()) begin
         return out_q[k];
      end
      return 9'h1AA;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic stepCycles(input int n);
      repeat (n) @(posedge clk_core);
      #1;
   endtask

   task automatic resetDut();
      stepCycles(1);
      src_en        = '0;
      clk_core_resn = 1'b0;
      stepCycles(2);
      clk_core_resn = 1'b1;
      out_q.delete();
      for (int i = 0; i < LC; i++) begin
         timeout_pulses[i] = 0;
         done_pulses[i]    = 0;
      end
      last_timeout_cyc = -1;
   endtask

   task automatic waitWords(input int n, input int budget, input string name);
      int c;
      c = 0;
      while ((out_q.size() < n) && (c < budget)) begin
         stepCycles(1);
         c++;
      end
      if (out_q.size() < n) begin
         checks++;
         errors++;
         $display("[TB] FAIL %s: timed out with %0d words, required %0d", name, out_q.size(), n);
      end
   endtask

   task automatic applyStimulus(input arb_vec_t v);
      resetDut();
      cfg_enable_mask   = v.mask;
      cfg_insert_header = 1'b1;
      cfg_timeout       = '0;
      m_axis_tready     = 1'b1;
      for (int i = 0; i < LC; i++) begin
         src_len[i] = 1;
      end
      src_en = v.en;
      waitWords(4, 60, "arb words");
      src_en = '0;
      checkOutput("arb first header", 32'(word_at(0)), {23'd0, 1'b0, v.exp_first});
      checkOutput("arb first beat last", 32'(word_at(1).last), 32'd1);
      checkOutput("arb second header", 32'(word_at(2)), {23'd0, 1'b0, v.exp_second});
   endtask

   initial begin
      int     f;
      int     pos;
      int     layer;
      int     drop_cyc;
      word_t  expw;

      vecs[0] = '{en: 3'b111, mask: 3'b111, exp_first: 8'h01, exp_second: 8'h02};
      vecs[1] = '{en: 3'b110, mask: 3'b111, exp_first: 8'h02, exp_second: 8'h03};
      vecs[2] = '{en: 3'b100, mask: 3'b111, exp_first: 8'h03, exp_second: 8'h03};
      vecs[3] = '{en: 3'b111, mask: 3'b110, exp_first: 8'h02, exp_second: 8'h03};
      vecs[4] = '{en: 3'b101, mask: 3'b100, exp_first: 8'h03, exp_second: 8'h03};
      vecs[5] = '{en: 3'b011, mask: 3'b010, exp_first: 8'h02, exp_second: 8'h02};

      // Reset state
      #12;
      checkOutput("reset s_tready", 32'(s_axis_tready), 32'd0);
      checkOutput("reset m_tvalid", 32'(m_axis_tvalid), 32'd0);
      checkOutput("reset m_tlast", 32'(m_axis_tlast), 32'd0);
      checkOutput("reset data_count", data_count, 32'd0);
      checkOutput("reset status_grant", 32'(status_grant), 32'd0);
      checkOutput("reset fifo_full", 32'(status_fifo_full), 32'd0);
      checkOutput("reset stat pulses", 32'({stat_frame_done, stat_timeout}), 32'd0);

      for (int v = 0; v < 6; v++) begin
         applyStimulus(vecs[v]);
      end

      // Round-robin fairness with 4-byte frames and headers
      resetDut();
      cfg_enable_mask = 3'b111;
      for (int i = 0; i < LC; i++) begin
         src_len[i] = 4;
      end
      src_en = 3'b111;
      waitWords(30, 200, "rr words");
      src_en = '0;
      for (int k = 0; k < 30; k++) begin
         f     = k / 5;
         pos   = k % 5;
         layer = f % 3;
         expw.last = (pos == 4);
         expw.data = (pos == 0) ? 8'(layer + 1) : 8'((layer << 6) | ((f / 3) * 4 + pos - 1));
         checkOutput($sformatf("rr word %0d", k), 32'(word_at(k)), 32'(expw));
      end

      // Frame atomicity: layer 1 waits for layer 0's gapped 10-byte frame
      resetDut();
      src_len[0] = 10;
      src_len[1] = 2;
      ready1_violations = 0;
      watch_atomic = 1'b1;
      for (int c = 0; (c < 300) && (out_q.size() < 12); c++) begin
         src_en[0] = (c % 3 != 2);
         if (src_seq[0] >= 2) begin
            src_en[1] = 1'b1;
         end
         stepCycles(1);
      end
      src_en = '0;
      watch_atomic = 1'b0;
      checkOutput("atomic words", 32'(out_q.size() >= 12), 32'd1);
      checkOutput("atomic header0", 32'(word_at(0)), 32'h001);
      checkOutput("atomic byte 9", 32'(word_at(9)), 32'h008);
      checkOutput("atomic last byte", 32'(word_at(10)), 32'h109);
      checkOutput("atomic next header", 32'(word_at(11)), 32'h002);
      checkOutput("atomic ready1 early", ready1_violations, 32'd0);
      checkOutput("atomic done0", done_pulses[0], 32'd1);

      // Timeout abort after 20 idle cycles
      resetDut();
      cfg_timeout = 16'd20;
      src_len[2]  = 10;
      src_len[0]  = 1;
      src_en      = 3'b100;
      for (int c = 0; c < 50; c++) begin
         stepCycles(1);
         if (src_seq[2] >= 3) begin
            break;
         end
      end
      src_en   = 3'b001;
      drop_cyc = cyc;
      waitWords(6, 80, "timeout words");
      src_en = '0;
      checkOutput("timeout header", 32'(word_at(0)), 32'h003);
      checkOutput("timeout byte 0", 32'(word_at(1)), 32'h080);
      checkOutput("timeout byte 2", 32'(word_at(3)), 32'h082);
      checkOutput("timeout marker", 32'(word_at(4)), 32'h1FF);
      checkOutput("timeout next grant", 32'(word_at(5)), 32'h001);
      checkOutput("timeout pulses l2", timeout_pulses[2], 32'd1);
      checkOutput("timeout pulses l0", timeout_pulses[0], 32'd0);
      checkOutput("timeout latency", 32'(last_timeout_cyc - drop_cyc), 32'd22);
      cfg_timeout = '0;

      // Backpressure: FIFO fills, then drains 40 bytes in order
      resetDut();
      cfg_insert_header = 1'b0;
      m_axis_tready     = 1'b0;
      src_len[0]        = 40;
      src_en            = 3'b001;
      stepCycles(60);
      checkOutput("bp data_count", data_count, 32'd16);
      checkOutput("bp fifo_full", 32'(status_fifo_full), 32'd1);
      checkOutput("bp s_tready", 32'(s_axis_tready), 32'd0);
      checkOutput("bp accepted", src_seq[0], 32'd16);
      m_axis_tready = 1'b1;
      waitWords(40, 200, "bp words");
      src_en = '0;
      for (int k = 0; k < 40; k++) begin
         expw.last = (k == 39);
         expw.data = 8'(k);
         checkOutput($sformatf("bp word %0d", k), 32'(word_at(k)), 32'(expw));
      end

      // Enable mask: layer 1 never wins; clearing bit 0 mid-frame still finishes layer 0
      resetDut();
      cfg_insert_header = 1'b1;
      cfg_enable_mask   = 3'b101;
      for (int i = 0; i < LC; i++) begin
         src_len[i] = 3;
      end
      src_en = 3'b111;
      for (int c = 0; (c < 20) && !status_grant[0]; c++) begin
         stepCycles(1);
      end
      cfg_enable_mask = 3'b100;
      waitWords(16, 200, "mask words");
      src_en = '0;
      checkOutput("mask header 0", 32'(word_at(0)), 32'h001);
      checkOutput("mask l0 last", 32'(word_at(3)), 32'h102);
      checkOutput("mask header 1", 32'(word_at(4)), 32'h003);
      checkOutput("mask l2 last", 32'(word_at(7)), 32'h182);
      checkOutput("mask header 2", 32'(word_at(8)), 32'h003);
      checkOutput("mask header 3", 32'(word_at(12)), 32'h003);
      checkOutput("mask l1 frames", done_pulses[1], 32'd0);
      cfg_enable_mask = 3'b111;

      // Reset during a DATA beat with a partly filled FIFO
      resetDut();
      m_axis_tready = 1'b0;
      src_len[0]    = 20;
      src_en        = 3'b001;
      for (int c = 0; (c < 30) && (src_seq[0] < 2); c++) begin
         stepCycles(1);
      end
      checkOutput("midrst fifo nonempty", 32'(data_count != 0), 32'd1);
      clk_core_resn = 1'b0;
      @(negedge clk_core);
      checkOutput("midrst s_tready", 32'(s_axis_tready), 32'd0);
      checkOutput("midrst m_tvalid", 32'(m_axis_tvalid), 32'd0);
      checkOutput("midrst data_count", data_count, 32'd0);
      checkOutput("midrst status_grant", 32'(status_grant), 32'd0);
      src_en = 3'b011;
      stepCycles(1);
      clk_core_resn = 1'b1;
      out_q.delete();
      m_axis_tready = 1'b1;
      waitWords(1, 20, "midrst words");
      src_en = '0;
      checkOutput("midrst first grant", 32'(word_at(0)), 32'h001);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
